// File: rtl/instr_mem_loader.sv
// Boot loader: takes a framed byte stream, assembles big-endian instructions into instr_mem
// and releases the processor from reset once the frame checksum matches.
module instr_mem_loader #(
    parameter int ADDR_SIZE   = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   imem_write_en,
    output logic [ADDR_WIDTH-1:0]  imem_write_addr,
    output logic [INSTR_WIDTH-1:0] imem_write_data,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    // state   | meaning
    // S_IDLE  | after reset, waiting for load_start
    // S_COUNT | shifting in the 4-byte word count N
    // S_DATA  | shifting in instruction bytes, one write per 4 bytes
    // S_CHECK | waiting for the XOR checksum byte
    // S_DONE  | load good, processor released from reset
    // S_ERROR | oversize count or bad checksum, processor held in reset
    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam int IDX_W = $clog2(ADDR_SIZE + 1);

    state_t           state, state_nxt;
    logic [1:0]       byte_cnt;
    logic [23:0]      shift_reg;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] word_total;
    logic [7:0]       checksum;

    logic        accept;
    logic        last_byte;
    logic        last_word;
    logic [31:0] assembled;

    assign byte_ready = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    assign busy       = byte_ready;
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign cpu_rst    = (state != S_DONE);

    assign accept     = byte_valid & byte_ready;
    assign last_byte  = (byte_cnt == 2'd3);
    assign last_word  = ((word_idx + IDX_W'(1)) == word_total);
    assign assembled  = {shift_reg, byte_data};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start) state_nxt = S_COUNT;
            end
            S_COUNT: begin
                if (accept && last_byte) begin
                    if (assembled == 32'd0)                 state_nxt = S_CHECK;
                    else if (assembled > 32'(ADDR_SIZE))    state_nxt = S_ERROR;
                    else                                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && last_byte && last_word) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (accept) state_nxt = (byte_data == checksum) ? S_DONE : S_ERROR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            byte_cnt        <= 2'd0;
            shift_reg       <= 24'd0;
            word_idx        <= '0;
            word_total      <= '0;
            checksum        <= 8'd0;
            imem_write_en   <= 1'b0;
            imem_write_addr <= '0;
            imem_write_data <= '0;
        end else begin
            state         <= state_nxt;
            imem_write_en <= 1'b0;

            if (load_start && !busy) begin
                byte_cnt <= 2'd0;
                word_idx <= '0;
                checksum <= 8'd0;
            end

            if (accept) begin
                byte_cnt  <= byte_cnt + 2'd1;
                shift_reg <= {shift_reg[15:0], byte_data};
                if (state != S_CHECK) checksum <= checksum ^ byte_data;

                // Counts above ADDR_SIZE go to ERROR, so the truncated value is only used when legal.
                if (state == S_COUNT && last_byte) word_total <= assembled[IDX_W-1:0];

                if (state == S_DATA && last_byte) begin
                    imem_write_en   <= 1'b1;
                    imem_write_addr <= ADDR_WIDTH'({word_idx, 2'b00});
                    imem_write_data <= INSTR_WIDTH'(assembled);
                    word_idx        <= word_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed-plus-random bench for instr_mem_loader: frames are built from the byte-level
// frame format, expected writes are queued up front and matched by a write monitor.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_write_en;
    logic [31:0] imem_write_addr;
    logic [31:0] imem_write_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    int compared   = 0;
    int mismatched = 0;
    int wr_count   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] words[1024];

    instr_mem_loader dut (
        .clk             (clk),
        .rst             (rst),
        .load_start      (load_start),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .byte_ready      (byte_ready),
        .imem_write_en   (imem_write_en),
        .imem_write_addr (imem_write_addr),
        .imem_write_data (imem_write_data),
        .cpu_rst         (cpu_rst),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        if (imem_write_en === 1'b1) begin
            wr_count++;
            compared++;
            assert (exp_addr_q.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write",
                       imem_write_addr, imem_write_data);
            end
            if (exp_addr_q.size() != 0) begin
                check("write_addr", imem_write_addr, exp_addr_q.pop_front());
                check("write_data", imem_write_data, exp_data_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max, input bit ls);
        int g;
        int t;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        if (g > 0) begin
            byte_valid = 1'b0;
            for (int i = 0; i < g; i++) tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        load_start = ls;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (byte_ready) break;
        end
        if (t == 100) begin
            compared++;
            mismatched++;
            $display("FAIL byte_timeout: observed byte_ready=0 for 100 cycles expected 1");
        end
        tick();
        load_start = 1'b0;
    endtask

    // limit < 0 sends the whole frame, otherwise only the first `limit` bytes.
    task automatic run_frame(input logic [31:0] n, input int limit, input bit flip,
                             input int gap_max, input int ls_at);
        logic [7:0] q[$];
        logic [7:0] chk;
        q   = {};
        chk = 8'h00;
        for (int s = 3; s >= 0; s--) q.push_back(n[s*8 +: 8]);
        if (n <= 32'd1024) begin
            for (int i = 0; i < int'(n); i++) begin
                for (int s = 3; s >= 0; s--) q.push_back(words[i][s*8 +: 8]);
                if (limit < 0 || (i + 1) * 4 <= limit - 4) begin
                    exp_addr_q.push_back(32'(i * 4));
                    exp_data_q.push_back(words[i]);
                end
            end
            foreach (q[k]) chk = chk ^ q[k];
            q.push_back(flip ? (chk ^ 8'h01) : chk);
        end
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        foreach (q[k]) begin
            if (limit >= 0 && k >= limit) break;
            send_byte(q[k], gap_max, (k == ls_at));
        end
        byte_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit e_done, input bit e_error,
                                input bit e_cpu_rst);
        repeat (2) tick();
        check({tag, "_done"},    32'(done),    32'(e_done));
        check({tag, "_error"},   32'(error),   32'(e_error));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(e_cpu_rst));
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_pending"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        int wr_before;
        rst        = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        // Reset and idle
        repeat (5) tick();
        check("idle_cpu_rst", 32'(cpu_rst),    32'd1);
        check("idle_ready",   32'(byte_ready), 32'd0);
        check("idle_busy",    32'(busy),       32'd0);
        check("idle_done",    32'(done),       32'd0);
        check("idle_error",   32'(error),      32'd0);
        check("idle_writes",  32'(wr_count),   32'd0);
        check("idle_addr",    imem_write_addr, 32'd0);
        check("idle_data",    imem_write_data, 32'd0);

        // Good two-word frame
        words[0] = 32'h2008_0005;
        words[1] = 32'h0109_5020;
        run_frame(32'd2, -1, 1'b0, 2, -1);
        check_status("good2", 1'b1, 1'b0, 1'b0);
        check("good2_writes", 32'(wr_count), 32'd2);
        check("hold_addr", imem_write_addr, 32'h4);
        check("hold_data", imem_write_data, 32'h0109_5020);

        // Same frame, corrupted checksum: writes still land
        run_frame(32'd2, -1, 1'b1, 2, -1);
        check_status("badchk", 1'b0, 1'b1, 1'b1);
        check("badchk_writes", 32'(wr_count), 32'd4);

        // Empty frame: checksum of the four zero count bytes
        run_frame(32'd0, -1, 1'b0, 1, -1);
        check_status("n0", 1'b1, 1'b0, 1'b0);

        // Oversized count
        wr_before = wr_count;
        run_frame(32'h0000_0401, -1, 1'b0, 1, -1);
        check_status("oversize", 1'b0, 1'b1, 1'b1);
        check("oversize_writes", 32'(wr_count - wr_before), 32'd0);

        // Reset after 6 data bytes with random gaps
        for (int i = 0; i < 3; i++) words[i] = $urandom();
        wr_before = wr_count;
        run_frame(32'd3, 10, 1'b0, 3, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_status("midrst", 1'b0, 1'b0, 1'b1);
        check("midrst_ready",  32'(byte_ready), 32'd0);
        check("midrst_writes", 32'(wr_count - wr_before), 32'd1);

        for (int i = 0; i < 3; i++) words[i] = $urandom();
        wr_before = wr_count;
        run_frame(32'd3, -1, 1'b0, 3, -1);
        check_status("after_rst", 1'b1, 1'b0, 1'b0);
        check("after_rst_writes", 32'(wr_count - wr_before), 32'd3);

        // Full-depth frame, back to back, load_start pulsed mid-data
        for (int i = 0; i < 1024; i++) words[i] = $urandom();
        wr_before = wr_count;
        run_frame(32'd1024, -1, 1'b0, 0, 2001);
        check_status("full", 1'b1, 1'b0, 1'b0);
        check("full_writes", 32'(wr_count - wr_before), 32'd1024);
        check("full_last_addr", imem_write_addr, 32'hFFC);
        check("full_last_data", imem_write_data, words[1023]);

        // Reload from DONE reasserts cpu_rst on COUNT entry
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_busy",    32'(busy),    32'd1);
        check("reload_done",    32'(done),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
